// File: rtl/snap_capture_ctrl.sv
// Snapshot capture sequencer: start edge, optional trigger wait, BRAM fill, done.
// Optional pre-capture sample delay is enabled with SNAP_CAPTURE_DELAY_EN.
module snap_capture_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11
) (
    input  logic              user_clk,
    input  logic              user_rst,
    input  logic [31:0]       ctrl_word,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              sync_in,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    output logic              bram_we,
    output logic              busy,
    output logic [31:0]       status_word
);

    localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DELAY,
        S_CAPT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              done_q, done_d;
    logic              start_prev_q, start_prev_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;
    logic [31:0]       status_q, status_d;
    logic [15:0]       dly_q, dly_d;

    logic start_edge;
    logic abort;
    logic launch;
    logic ctrl_unused;

    assign start_edge  = ctrl_word[0] & ~start_prev_q;
    assign abort       = ctrl_word[2];
    assign ctrl_unused = ^ctrl_word;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        done_d       = done_q;
        start_prev_d = ctrl_word[0];
        we_d         = 1'b0;
        addr_d       = addr_q;
        data_d       = data_q;
        dly_d        = dly_q;
        launch       = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_edge) begin
                    count_d = '0;
                    done_d  = 1'b0;
                    if (ctrl_word[1]) state_d = S_WAIT;
                    else              launch  = 1'b1;
                end
            end
            S_WAIT: begin
                if (abort)        state_d = S_IDLE;
                else if (sync_in) launch  = 1'b1;
            end
            S_DELAY: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (din_valid) begin
                    dly_d = dly_q - 16'd1;
                    if (dly_q == 16'd1) state_d = S_CAPT;
                end
            end
            S_CAPT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (din_valid) begin
                    we_d    = 1'b1;
                    addr_d  = count_q[ADDR_W-1:0];
                    data_d  = din;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A zero delay skips the DELAY state entirely
        if (launch) begin
`ifdef SNAP_CAPTURE_DELAY_EN
            if (ctrl_word[31:16] != 16'd0) begin
                state_d = S_DELAY;
                dly_d   = ctrl_word[31:16];
            end else begin
                state_d = S_CAPT;
            end
`else
            state_d = S_CAPT;
`endif
        end

        busy_d = (state_d == S_WAIT) || (state_d == S_DELAY) ||
                 (state_d == S_CAPT);

        status_d             = '0;
        status_d[31]         = done_q;
        status_d[30]         = busy_q;
        status_d[ADDR_W:0]   = count_q;
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            done_q       <= 1'b0;
            start_prev_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            busy_q       <= 1'b0;
            status_q     <= '0;
            dly_q        <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            done_q       <= done_d;
            start_prev_q <= start_prev_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
            status_q     <= status_d;
            dly_q        <= dly_d;
        end
    end

    assign bram_we     = we_q;
    assign bram_addr   = addr_q;
    assign bram_din    = data_q;
    assign busy        = busy_q;
    assign status_word = status_q;

endmodule

// File: tb/tb_snap_capture_ctrl.sv
// Directed bench for snap_capture_ctrl with ADDR_W=4 (16-sample capture).
// Covers reset, ramp fill, trigger wait, gaps, restart, abort and delay.
module tb_snap_capture_ctrl;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk;
    logic          rst;
    logic [31:0]   ctrl;
    logic [DW-1:0] din;
    logic          vld;
    logic          sync;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic          bram_we;
    logic          busy;
    logic [31:0]   status;

    int checks;
    int errors;

    snap_capture_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .user_clk   (clk),
        .user_rst   (rst),
        .ctrl_word  (ctrl),
        .din        (din),
        .din_valid  (vld),
        .sync_in    (sync),
        .bram_addr  (bram_addr),
        .bram_din   (bram_din),
        .bram_we    (bram_we),
        .busy       (busy),
        .status_word(status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ctrl;
        logic        vld;
        logic [31:0] d;
        logic        ewe;
        logic [3:0]  eaddr;
        logic        ebusy;
    } vec_t;

    vec_t tv[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        found;
        logic [31:0] first_d;
        logic [31:0] exp_first;

        checks = 0;
        errors = 0;

        // restart from DONE, valid gaps, mid-capture start edge, abort
        tv[0]  = '{32'h0, 1'b0, 32'h0,  1'b0, 4'd0, 1'b0};
        tv[1]  = '{32'h1, 1'b0, 32'h0,  1'b0, 4'd0, 1'b1};
        tv[2]  = '{32'h1, 1'b1, 32'hA0, 1'b1, 4'd0, 1'b1};
        tv[3]  = '{32'h1, 1'b0, 32'hEE, 1'b0, 4'd0, 1'b1};
        tv[4]  = '{32'h0, 1'b1, 32'hA1, 1'b1, 4'd1, 1'b1};
        tv[5]  = '{32'h1, 1'b1, 32'hA2, 1'b1, 4'd2, 1'b1};
        tv[6]  = '{32'h1, 1'b0, 32'hEE, 1'b0, 4'd0, 1'b1};
        tv[7]  = '{32'h1, 1'b1, 32'hA3, 1'b1, 4'd3, 1'b1};
        tv[8]  = '{32'h1, 1'b1, 32'hA4, 1'b1, 4'd4, 1'b1};
        tv[9]  = '{32'h1, 1'b1, 32'hA5, 1'b1, 4'd5, 1'b1};
        tv[10] = '{32'h5, 1'b1, 32'hA6, 1'b0, 4'd0, 1'b0};
        tv[11] = '{32'h0, 1'b1, 32'hA7, 1'b0, 4'd0, 1'b0};

        rst  = 1'b1;
        ctrl = 32'h1;
        din  = '0;
        vld  = 1'b0;
        sync = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // start held across reset release must not launch
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("rst_we", {31'd0, bram_we}, 32'd0);
            chk("rst_status", status, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
        end

        // ramp fill of all 16 locations
        ctrl = 32'h0;
        tick();
        ctrl = 32'h1;
        tick();
        chk("ramp_busy", {31'd0, busy}, 32'd1);
        chk("ramp_we0", {31'd0, bram_we}, 32'd0);
        for (int j = 0; j < 16; j++) begin
            din = j;
            vld = 1'b1;
            tick();
            chk("ramp_we", {31'd0, bram_we}, 32'd1);
            chk("ramp_addr", {28'd0, bram_addr}, j);
            chk("ramp_data", bram_din, j);
        end
        chk("ramp_busy_end", {31'd0, busy}, 32'd0);
        din = 32'hFF;
        tick();
        chk("ramp_we_end", {31'd0, bram_we}, 32'd0);
        chk("ramp_status", status, 32'h80000010);

        foreach (tv[i]) begin
            ctrl = tv[i].ctrl;
            vld  = tv[i].vld;
            din  = tv[i].d;
            tick();
            chk("tv_we", {31'd0, bram_we}, {31'd0, tv[i].ewe});
            if (tv[i].ewe) begin
                chk("tv_addr", {28'd0, bram_addr}, {28'd0, tv[i].eaddr});
                chk("tv_data", bram_din, tv[i].d);
            end
            chk("tv_busy", {31'd0, busy}, {31'd0, tv[i].ebusy});
        end
        chk("abort_status", status, 32'h00000006);

        // restart after abort begins at address 0
        ctrl = 32'h1;
        din  = 32'h55;
        tick();
        din = 32'h66;
        tick();
        chk("rs_we", {31'd0, bram_we}, 32'd1);
        chk("rs_addr", {28'd0, bram_addr}, 32'd0);
        chk("rs_data", bram_din, 32'h66);
        ctrl = 32'h5;
        tick();
        chk("rs_abort_busy", {31'd0, busy}, 32'd0);
        ctrl = 32'h0;
        tick();

        // trigger wait; sync coincident with start edge is ignored
        ctrl = 32'h3;
        sync = 1'b1;
        din  = 32'h11;
        tick();
        chk("trg_busy", {31'd0, busy}, 32'd1);
        sync = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("trg_nowe", {31'd0, bram_we}, 32'd0);
        end
        sync = 1'b1;
        tick();
        chk("trg_we_sync", {31'd0, bram_we}, 32'd0);
        sync = 1'b0;
        din  = 32'h77;
        tick();
        chk("trg_we", {31'd0, bram_we}, 32'd1);
        chk("trg_addr", {28'd0, bram_addr}, 32'd0);
        chk("trg_data", bram_din, 32'h77);
        ctrl = 32'h6;
        tick();
        ctrl = 32'h0;
        tick();

        // delay field: first captured sample index
`ifdef SNAP_CAPTURE_DELAY_EN
        exp_first = 32'd3;
`else
        exp_first = 32'd0;
`endif
        ctrl    = 32'h00030001;
        vld     = 1'b1;
        din     = 32'hDEAD;
        found   = 1'b0;
        first_d = '0;
        tick();
        for (int k = 0; k < 20; k++) begin
            if (!found) begin
                din = k;
                tick();
                if (bram_we) begin
                    found   = 1'b1;
                    first_d = bram_din;
                end
            end
        end
        chk("dly_found", {31'd0, found}, 32'd1);
        chk("dly_first", first_d, exp_first);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/snap_capture_ctrl.md
Name: snap_capture_ctrl

Overview:
- Consumes the 32-bit software control word from the startsnap register's user_data_out, in the user_clk domain.
- Sequences a one-shot snapshot of a streaming data bus into a BRAM: start edge detect, optional trigger wait, fill, done.
- Exports a status word that software reads back through a simulink2ppc register.
- Sits directly downstream of the startsnap register, beside the snapshot BRAM.

Parameters:
- DATA_W, 32, width of captured sample bus and BRAM data.
- ADDR_W, 11, BRAM address width; capture length DEPTH = 2^ADDR_W samples.

Ports:
- user_clk  input  1  sole clock; all logic rising-edge.
- user_rst  input  1  asynchronous, active-high reset.
- ctrl_word  input  32  startsnap register value. Bit0 start (rising edge). Bit1 wait_trig. Bit2 abort (level). Bits31:16 delay (feature only).
- din  input  DATA_W  sample data.
- din_valid  input  1  sample qualifier.
- sync_in  input  1  external trigger pulse.
- bram_addr  output  ADDR_W  BRAM write address.
- bram_din  output  DATA_W  BRAM write data.
- bram_we  output  1  BRAM write enable.
- busy  output  1  high in WAIT_TRIG, DELAY or CAPTURE.
- status_word  output  32  bit31 done, bit30 busy, bits ADDR_W:0 samples written.

Behaviour:
- Interface: one clock, user_clk; user_rst is asynchronous, active-high.
- Reset values:
  - state IDLE; bram_we=0, bram_addr=0, bram_din=0, busy=0, status_word=0, count=0.
  - start_prev resets to 1, so a start bit held high across reset release does not launch a capture.
- start_edge = ctrl_word[0] & ~start_prev; start_prev registers ctrl_word[0] every cycle.
- States:
  - IDLE: start_edge -> WAIT_TRIG if ctrl_word[1], else CAPTURE; count cleared to 0 and done cleared on the transition.
  - WAIT_TRIG: sync_in=1 -> CAPTURE. A sync_in in the same cycle as start_edge is not honoured; the trigger must arrive at least one cycle after entry.
  - CAPTURE: each cycle with din_valid=1 registers bram_din=din, bram_addr=count[ADDR_W-1:0], bram_we=1 (latency 1 cycle), then count+1. After the write with count=DEPTH-1 -> DONE. din_valid=0 -> bram_we=0 next cycle, address holds.
  - DONE: done=1, busy=0; count holds at DEPTH. start_edge -> restart exactly as from IDLE (count and done cleared).
- count is ADDR_W+1 bits; it never wraps and the address never exceeds DEPTH-1.
- start_edge while busy is ignored.
- abort (ctrl_word[2]=1) in any busy state -> IDLE next cycle; no bram_we that cycle; count retained in status_word; done stays 0. Abort has priority over start_edge and sync_in in the same cycle.
- status_word is registered and updates one cycle after count/state change.

Optional Feature:
- Macro: SNAP_CAPTURE_DELAY_EN.
- Defined: adds DELAY state between trigger/start and CAPTURE.
  - 16-bit delay counter loaded from ctrl_word[31:16] on entry.
  - Decrements on each din_valid cycle; CAPTURE is entered when it reaches 0.
  - Delay 0 behaves as if the feature were absent. Abort applies in DELAY.
- Undefined: ctrl_word[31:16] ignored; no DELAY state.

Test Plan:
- Reset with ctrl_word=0x1 held, release, hold 20 cycles -> no bram_we, status_word=0, busy=0.
- ADDR_W=4, ctrl_word 0->0x1, din=ramp 0..15, din_valid=1 -> 16 writes at addr 0..15 with data 0..15, first bram_we 2 cycles after the edge. Then status_word=0x80000010, busy=0.
- ctrl_word 0->0x3, sync_in pulsed 10 cycles later -> no writes before sync. Writes start the cycle after sync+1; sync coincident with the start edge is ignored.
- During capture, din_valid toggles 1,0,1 -> addresses contiguous, no write on invalid cycles. A start edge mid-capture changes nothing.
- Abort (0x5) after 6 samples -> IDLE, status_word=0x00000006. A new start edge restarts at addr 0.
- With SNAP_CAPTURE_DELAY_EN, ctrl_word=0x00030001 -> first capture of sample index 3; with the macro undefined -> sample index 0.
